dac_pulse_train_gen: RTL and testbench

//  Upstream stage of the DAC SPI controller. Generates one channel's rectangular stimulation pulse train.

---
 rtl/osc1_pkg.sv | 26 ++
 rtl/dac_pulse_train_gen_buffer.sv | 76 +++++++
 rtl/dac_pulse_train_gen.sv | 149 ++++++++++++++
 tb/tb_dac_pulse_train_gen.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc1_pkg.sv
// Shared definitions for the oscillator / DAC stimulation path.
//   - FSM state encoding of the pulse train generator
//   - DAC request modes and the SPI write address
//   - default DAC idle (midscale) code
//   - helper that checks a pulse timing configuration
package osc1_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HIGH  = 2'd1;
   localparam logic [1:0] ST_LOW   = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   localparam logic [1:0] DAC_MODE_NOP   = 2'b00;
   localparam logic [1:0] DAC_MODE_WRITE = 2'b01;
   localparam logic [1:0] DAC_MODE_READ  = 2'b10;

   localparam logic [7:0]  DAC_ADDR_WRITE    = 8'h01;
   localparam logic [15:0] DEFAULT_IDLE_CODE = 16'h8000;

   // A pulse needs a non-empty high phase and a non-empty low phase.
   function automatic logic timing_cfg_ok(input logic [31:0] width,
                                          input logic [31:0] period);
      return (width != 32'd0) && (period > width);
   endfunction

endpackage

// File: rtl/dac_pulse_train_gen_buffer.sv
// dac_req_buffer: DAC write request buffer = output register + one pending slot.
//   clk, rst     clock / async active-high reset
//   enq          push a code this cycle
//   enq_data     code to push
//   ovr_clr      clear the sticky overrun flag
//   dac_ready    downstream accepts the presented request
//   out_valid    request presented downstream
//   out_data     presented code; holds last code when out_valid=0
//   empty        neither output register nor pending slot holds a code
//   overrun      sticky: pending code was overwritten before being sent
module dac_req_buffer #(
   parameter int                DATA_W     = 16,
   parameter logic [DATA_W-1:0] RESET_CODE = {1'b1, {(DATA_W-1){1'b0}}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enq,
   input  logic [DATA_W-1:0] enq_data,
   input  logic              ovr_clr,
   input  logic              dac_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              empty,
   output logic              overrun
);

   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic              pend_valid_q;
   logic [DATA_W-1:0] pend_data_q;
   logic              overrun_q;
   logic              accept;

   assign accept = out_valid_q && dac_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= RESET_CODE;
         pend_valid_q <= 1'b0;
         pend_data_q  <= RESET_CODE;
         overrun_q    <= 1'b0;
      end else begin
         if (accept) begin
            // Accept with a pending code: pending advances first so codes
            // leave in enqueue order; a simultaneous push takes the slot.
            if (pend_valid_q) begin
               out_data_q   <= pend_data_q;
               pend_valid_q <= enq;
               if (enq) pend_data_q <= enq_data;
            end else begin
               out_valid_q <= enq;
               if (enq) out_data_q <= enq_data;
            end
         end else if (enq) begin
            if (!out_valid_q) begin
               out_valid_q <= 1'b1;
               out_data_q  <= enq_data;
            end else begin
               // latest code wins over an unsent pending one
               pend_valid_q <= 1'b1;
               pend_data_q  <= enq_data;
            end
         end

         if (enq && !accept && pend_valid_q) overrun_q <= 1'b1;
         else if (ovr_clr)                   overrun_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign empty     = !out_valid_q && !pend_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: rtl/dac_pulse_train_gen.sv
// dac_pulse_train_gen: one channel's rectangular stimulation pulse train.
// Emits a DAC code on every level transition through a valid/ready request
// port consumed by the DAC SPI controller.
//   cfg_amplitude/pulse_width/period/n_pulses  latched on an accepted trigger
//   trigger / abort      start (IDLE only) / stop and return to IDLE_CODE
//   busy, pulse_active   train running / high phase
//   done, cfg_error      end-of-train strobe / bad-config strobe (with done)
//   overrun              sticky: a pending code was overwritten
//   dac_valid/mode/data  write request; dac_ready accepts it
module dac_pulse_train_gen
   import osc1_pkg::*;
#(
   parameter int                DATA_W    = 16,
   parameter int                TIMER_W   = 24,
   parameter int                COUNT_W   = 16,
   parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(DEFAULT_IDLE_CODE)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  cfg_amplitude,
   input  logic [TIMER_W-1:0] cfg_pulse_width,
   input  logic [TIMER_W-1:0] cfg_period,
   input  logic [COUNT_W-1:0] cfg_n_pulses,
   input  logic               trigger,
   input  logic               abort,
   output logic               busy,
   output logic               pulse_active,
   output logic               done,
   output logic               cfg_error,
   output logic               overrun,
   output logic               dac_valid,
   output logic [1:0]         dac_mode,
   output logic [DATA_W-1:0]  dac_data,
   input  logic               dac_ready
);

   logic [1:0]         state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [COUNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
   logic [DATA_W-1:0]  amp_q;
   logic [TIMER_W-1:0] width_q;
   logic [TIMER_W-1:0] period_q;
   logic [COUNT_W-1:0] n_q;
   logic               err_q;
   logic [DATA_W-1:0]  last_enq_q;

   logic               start, start_ok;
   logic               enq;
   logic [DATA_W-1:0]  enq_data;
   logic               buf_empty;

   assign start    = (state_q == ST_IDLE) && trigger && !abort;
   assign start_ok = start && timing_cfg_ok(32'(cfg_pulse_width), 32'(cfg_period));

   // timer_q counts down the remaining cycles of the current phase
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      pulse_cnt_d = pulse_cnt_q;
      enq         = 1'b0;
      enq_data    = IDLE_CODE;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d     = ST_HIGH;
               timer_d     = cfg_pulse_width - TIMER_W'(1);
               pulse_cnt_d = '0;
               enq         = 1'b1;
               enq_data    = cfg_amplitude;
            end
         end
         ST_HIGH, ST_LOW: begin
            if (abort) begin
               enq     = (last_enq_q != IDLE_CODE);
               state_d = ST_DRAIN;
            end else if (timer_q == '0) begin
               if (state_q == ST_HIGH) begin
                  state_d     = ST_LOW;
                  timer_d     = period_q - width_q - TIMER_W'(1);
                  pulse_cnt_d = pulse_cnt_q + COUNT_W'(1);
                  enq         = 1'b1;
               end else if ((n_q != '0) && (pulse_cnt_q == n_q)) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d  = ST_HIGH;
                  timer_d  = width_q - TIMER_W'(1);
                  enq      = 1'b1;
                  enq_data = amp_q;
               end
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         ST_DRAIN: begin
            if (buf_empty) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         pulse_cnt_q <= '0;
         amp_q       <= IDLE_CODE;
         width_q     <= '0;
         period_q    <= '0;
         n_q         <= '0;
         err_q       <= 1'b0;
         last_enq_q  <= IDLE_CODE;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         pulse_cnt_q <= pulse_cnt_d;
         err_q       <= start && !start_ok;
         if (start) begin
            amp_q    <= cfg_amplitude;
            width_q  <= cfg_pulse_width;
            period_q <= cfg_period;
            n_q      <= cfg_n_pulses;
         end
         if (enq) last_enq_q <= enq_data;
      end
   end

   dac_req_buffer #(
      .DATA_W     (DATA_W),
      .RESET_CODE (IDLE_CODE)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .enq       (enq),
      .enq_data  (enq_data),
      .ovr_clr   (start),
      .dac_ready (dac_ready),
      .out_valid (dac_valid),
      .out_data  (dac_data),
      .empty     (buf_empty),
      .overrun   (overrun)
   );

   assign busy         = (state_q != ST_IDLE);
   assign pulse_active = (state_q == ST_HIGH);
   assign done         = err_q || ((state_q == ST_DRAIN) && buf_empty);
   assign cfg_error    = err_q;
   assign dac_mode     = dac_valid ? DAC_MODE_WRITE : DAC_MODE_NOP;

endmodule

// File: tb/tb_dac_pulse_train_gen.sv
// Scoreboard bench for dac_pulse_train_gen. The reference model derives the
// waveform from the trigger time with arithmetic on the pulse period and
// keeps the request buffer as a bounded queue of codes.
module tb_dac_pulse_train_gen;

   localparam logic [15:0] IDLE = 16'h8000;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cfg_amplitude;
   logic [23:0] cfg_pulse_width;
   logic [23:0] cfg_period;
   logic [15:0] cfg_n_pulses;
   logic        trigger, abort, dac_ready;
   logic        busy, pulse_active, done, cfg_error, overrun, dac_valid;
   logic [1:0]  dac_mode;
   logic [15:0] dac_data;

   dac_pulse_train_gen #(
      .DATA_W    (16),
      .TIMER_W   (24),
      .COUNT_W   (16),
      .IDLE_CODE (16'h8000)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_amplitude   (cfg_amplitude),
      .cfg_pulse_width (cfg_pulse_width),
      .cfg_period      (cfg_period),
      .cfg_n_pulses    (cfg_n_pulses),
      .trigger         (trigger),
      .abort           (abort),
      .busy            (busy),
      .pulse_active    (pulse_active),
      .done            (done),
      .cfg_error       (cfg_error),
      .overrun         (overrun),
      .dac_valid       (dac_valid),
      .dac_mode        (dac_mode),
      .dac_data        (dac_data),
      .dac_ready       (dac_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        busy, pulse, done, err, ovr, valid;
      logic [1:0]  mode;
      logic [15:0] data;
   } status_t;

   typedef struct {
      logic [15:0] code;
      int          c;
   } xfer_t;

   status_t exp_q[$];
   xfer_t   xfer_q[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit mon_en = 1'b0;
   int last_done_cyc = -1, last_err_cyc = -1, xfer_count = 0;
   logic [15:0] last_xfer_code = 16'h0000;

   // stimulus plan
   logic [15:0] plan_amp;
   int plan_w, plan_p, plan_n;
   int rdy_div = 1;
   bit rdy_hold = 1'b0;

   // reference model state
   bit          m_run, m_drain, m_err, m_ovr;
   int          m_t0, m_w, m_p, m_n;
   logic [15:0] m_amp, m_last_enq, m_last_out;
   logic [15:0] mq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_drain = 0; m_err = 0; m_ovr = 0;
      m_t0 = 0; m_w = 0; m_p = 1; m_n = 0;
      m_amp = IDLE; m_last_enq = IDLE; m_last_out = IDLE;
      mq.delete();
   endtask

   // One cycle of the reference: predicts this cycle's outputs, then
   // applies this cycle's inputs to form the next cycle.
   task automatic model_step();
      status_t     e;
      xfer_t       x;
      int          r, k, ph;
      bit          enq, acc;
      logic [15:0] code;
      r = 0; k = 0; ph = 0; enq = 0; code = IDLE;
      if (m_run && !m_drain) begin
         r  = cyc - m_t0;
         k  = (r - 1) / m_p;
         ph = (r - 1) % m_p;
      end
      e.busy  = m_run;
      e.pulse = m_run && !m_drain && (ph < m_w);
      e.done  = m_err || (m_drain && mq.size() == 0);
      e.err   = m_err;
      e.ovr   = m_ovr;
      e.valid = (mq.size() > 0);
      e.mode  = e.valid ? 2'b01 : 2'b00;
      if (e.valid) m_last_out = mq[0];
      e.data  = m_last_out;
      exp_q.push_back(e);

      acc = (mq.size() > 0) && dac_ready;
      if (acc) begin
         x.code = mq[0];
         x.c    = cyc;
         xfer_q.push_back(x);
      end

      m_err = 0;
      if (!m_run) begin
         if (trigger && !abort) begin
            m_ovr = 0;
            m_amp = cfg_amplitude;
            m_w   = int'(cfg_pulse_width);
            m_p   = int'(cfg_period);
            m_n   = int'(cfg_n_pulses);
            if (m_w == 0 || m_p <= m_w) begin
               m_err = 1;
               m_p   = 1;
            end else begin
               m_run = 1; m_drain = 0; m_t0 = cyc;
               enq = 1; code = m_amp;
            end
         end
      end else if (m_drain) begin
         if (mq.size() == 0) begin
            m_run = 0; m_drain = 0;
         end
      end else if (abort) begin
         if (m_last_enq != IDLE) begin
            enq = 1; code = IDLE;
         end
         m_drain = 1;
      end else if (ph == m_w - 1) begin
         enq = 1; code = IDLE;
      end else if (ph == m_p - 1) begin
         if (m_n != 0 && k + 1 == m_n) m_drain = 1;
         else begin
            enq = 1; code = m_amp;
         end
      end

      if (acc) void'(mq.pop_front());
      if (enq) begin
         m_last_enq = code;
         if (!acc && mq.size() == 2) begin
            mq[1] = code;
            m_ovr = 1;
         end else begin
            mq.push_back(code);
         end
      end
   endtask

   task automatic step(input logic trig, input logic abt);
      @(posedge clk);
      #1;
      cyc++;
      trigger   = trig;
      abort     = abt;
      dac_ready = !rdy_hold && ((cyc % rdy_div) == 0);
      if (trig && !m_run) begin
         cfg_amplitude   = plan_amp;
         cfg_pulse_width = 24'(plan_w);
         cfg_period      = 24'(plan_p);
         cfg_n_pulses    = 16'(plan_n);
      end else begin
         cfg_amplitude   = 16'($urandom);
         cfg_pulse_width = 24'($urandom);
         cfg_period      = 24'($urandom);
         cfg_n_pulses    = 16'($urandom);
      end
      model_step();
      mon_en = 1'b1;
   endtask

   // monitor: per-cycle status scoreboard plus transfer scoreboard
   initial begin
      status_t e;
      xfer_t   x;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL status_queue @cyc %0d: got empty expected entry", cyc);
            end else begin
               e = exp_q.pop_front();
               check("busy",         32'(busy),         32'(e.busy));
               check("pulse_active", 32'(pulse_active), 32'(e.pulse));
               check("done",         32'(done),         32'(e.done));
               check("cfg_error",    32'(cfg_error),    32'(e.err));
               check("overrun",      32'(overrun),      32'(e.ovr));
               check("dac_valid",    32'(dac_valid),    32'(e.valid));
               check("dac_mode",     32'(dac_mode),     32'(e.mode));
               check("dac_data",     32'(dac_data),     32'(e.data));
            end
            if (done)      last_done_cyc = cyc;
            if (cfg_error) last_err_cyc  = cyc;
            if (dac_valid && dac_ready) begin
               xfer_count++;
               last_xfer_code = dac_data;
               if (xfer_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_write @cyc %0d: got %0h expected none", cyc, dac_data);
               end else begin
                  x = xfer_q.pop_front();
                  check("xfer_code",  32'(dac_data), 32'(x.code));
                  check("xfer_cycle", 32'(cyc),      32'(x.c));
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_trig, budget, abort_rel, x0;
      bit trg, abt;
      rst = 1'b1; trigger = 0; abort = 0; dac_ready = 0;
      cfg_amplitude = '0; cfg_pulse_width = '0; cfg_period = '0; cfg_n_pulses = '0;
      plan_amp = IDLE; plan_w = 1; plan_p = 2; plan_n = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",      32'(busy),         32'd0);
      check("rst_pulse",     32'(pulse_active), 32'd0);
      check("rst_done",      32'(done),         32'd0);
      check("rst_cfg_error", 32'(cfg_error),    32'd0);
      check("rst_overrun",   32'(overrun),      32'd0);
      check("rst_valid",     32'(dac_valid),    32'd0);
      check("rst_mode",      32'(dac_mode),     32'd0);
      check("rst_data",      32'(dac_data),     32'h8000);
      rst = 1'b0;

      for (int tr = 0; tr < 40; tr++) begin
         abort_rel = -1;
         rdy_div   = 1;
         case (tr)
            0: begin plan_amp = 16'hC000; plan_w = 3; plan_p = 8; plan_n = 2; end
            1: begin plan_amp = 16'hC000; plan_w = 1; plan_p = 2; plan_n = 2; rdy_div = 8; end
            2: begin plan_amp = 16'hC000; plan_w = 3; plan_p = 8; plan_n = 0; abort_rel = 2; end
            3: begin plan_amp = 16'hC000; plan_w = 5; plan_p = 5; plan_n = 1; end
            default: begin
               plan_amp = 16'($urandom);
               plan_w   = int'($urandom_range(0, 4));
               plan_p   = plan_w + int'($urandom_range(0, 6));
               plan_n   = int'($urandom_range(0, 3));
               case ($urandom % 5)
                  0: rdy_div = 1;
                  1: rdy_div = 2;
                  2: rdy_div = 3;
                  3: rdy_div = 5;
                  default: rdy_div = 8;
               endcase
               if (plan_n == 0 || ($urandom % 4) == 0) abort_rel = int'($urandom_range(1, 25));
            end
         endcase

         if (tr == 1) while (((cyc + 1) % 8) != 0) step(0, 0);
         if (tr >= 4 && (tr % 5) == 4) step(1, 1);   // trigger+abort in IDLE: nothing starts

         x0 = xfer_count;
         step(1, 0);
         t_trig = cyc;
         budget = 0;
         while ((m_run || m_err) && budget < 400) begin
            abt = (abort_rel >= 0) && (cyc + 1 - t_trig == abort_rel);
            trg = m_run && (($urandom % 8) == 0);
            step(trg, abt);
            budget++;
         end
         if (budget >= 400) begin
            tests++; fails++;
            $display("FAIL train_timeout tr %0d: got >=400 cycles expected completion", tr);
         end
         repeat (2) step(0, 0);

         case (tr)
            0: check("t1_done_cycle", 32'(last_done_cyc - t_trig), 32'd17);
            1: begin
               check("t2_overrun",   32'(overrun),        32'd1);
               check("t2_last_code", 32'(last_xfer_code), 32'h8000);
            end
            2: begin
               check("t3_writes",    32'(xfer_count - x0), 32'd2);
               check("t3_last_code", 32'(last_xfer_code),  32'h8000);
               check("t3_busy",      32'(busy),            32'd0);
            end
            3: begin
               check("t4_done_cycle", 32'(last_done_cyc - t_trig), 32'd1);
               check("t4_err_cycle",  32'(last_err_cyc - t_trig),  32'd1);
               check("t4_writes",     32'(xfer_count - x0),        32'd0);
            end
            default: ;
         endcase
      end

      // reset while a request is waiting for dac_ready
      rdy_hold = 1'b1;
      plan_amp = 16'hC000; plan_w = 3; plan_p = 8; plan_n = 0;
      step(1, 0);
      repeat (3) step(0, 0);
      @(negedge clk);
      check("pre_reset_valid", 32'(dac_valid), 32'd1);
      check("xfer_leftover",   32'(xfer_q.size()), 32'd0);
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      check("rst2_busy",    32'(busy),         32'd0);
      check("rst2_pulse",   32'(pulse_active), 32'd0);
      check("rst2_done",    32'(done),         32'd0);
      check("rst2_err",     32'(cfg_error),    32'd0);
      check("rst2_overrun", 32'(overrun),      32'd0);
      check("rst2_valid",   32'(dac_valid),    32'd0);
      check("rst2_mode",    32'(dac_mode),     32'd0);
      check("rst2_data",    32'(dac_data),     32'h8000);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
